garage_door_activation_scheduler: RTL and testbench
===================================================

Name: garage_door_activation_scheduler

Overview:
- Front-end scheduler for the garage door motor FSM: collects open/close requests from NUM_REQ sources (remote, wall button, keypad, ...).
- Debounces each source, arbitrates round-robin and issues single-cycle Activate pulses to the motor controller.
- Supervises motion (start check, run timeout, illegal limit-switch combination) and optionally auto-closes an open door.

Parameters:
- NUM_REQ, 4, number of request sources (2..8).
- DEB_CYCLES, 16, consecutive stable synchronized cycles required to change a debounced level.
- MOVE_TIMEOUT_CYCLES, 5000, maximum motor run cycles before fault.
- AUTO_CLOSE_CYCLES, 1000, idle-open cycles before auto-close (AUTO_CLOSE_EN only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  raw asynchronous request buttons, active-high level
- up_max  in  1  door fully-open limit switch
- dn_max  in  1  door fully-closed limit switch
- up_m  in  1  motor-up status from motor FSM
- dn_m  in  1  motor-down status from motor FSM
- fault_clr  in  1  synchronous fault acknowledge
- activate  out  1  one-cycle pulse to motor FSM Activate input
- grant  out  NUM_REQ  one-hot, asserted with activate for a served source; all-zero for an auto-close issue
- busy  out  1  high in every state except IDLE
- fault  out  1  high in FAULT

Behaviour:
- Reset: all outputs 0; state IDLE; pending 0; rr pointer 0; debounced levels 0; all counters 0.
- Input path:
  - Each req bit goes through a 2-FF synchronizer, then a per-bit debounce counter.
  - A rising edge of the debounced level sets pending[i], but only in IDLE.
  - Edges in any other state are discarded.
  - Latency from req rise to pending set: 2 + DEB_CYCLES cycles.
- IDLE:
  - up_max&dn_max=1 -> FAULT (highest priority).
  - Otherwise, if pending!=0 and exactly one limit switch is high -> ISSUE.
  - If pending!=0 with both switches low -> pending cleared, stay IDLE.
- ISSUE (1 cycle):
  - activate=1; grant = first pending bit at or after rr pointer (wrapping NUM_REQ-1 -> 0).
  - That bit is cleared, rr pointer <= winner+1 mod NUM_REQ.
  - All other pending bits are cleared (one motion per arbitration).
  - -> WAIT_START.
- WAIT_START:
  - up_m|dn_m seen within 3 cycles -> MOVING, cycle counter cleared.
  - Otherwise -> FAULT.
- MOVING:
  - Counter increments each cycle.
  - up_m=0 and dn_m=0 -> IDLE.
  - Counter reaches MOVE_TIMEOUT_CYCLES-1 while still moving -> FAULT.
  - up_m&dn_m=1 -> FAULT immediately.
- FAULT:
  - fault=1, activate=0, pending held cleared, debounce continues.
  - fault_clr=1 -> IDLE next cycle.
  - fault_clr is ignored in other states.
- Simultaneous events:
  - FAULT conditions win over transitions.
  - User pending wins over auto-close in the same cycle.
- Mid-operation reset forces IDLE with outputs 0 on the asynchronous edge.
- Counters saturate, never wrap.

Optional Feature:
- Macro: AUTO_CLOSE_EN.
- With AUTO_CLOSE_EN defined:
  - Idle counter runs in IDLE while up_max=1, dn_max=0, pending=0.
  - It clears on any other condition.
  - On reaching AUTO_CLOSE_CYCLES-1 -> ISSUE with grant=0; rr pointer unchanged.
- Without it: no counter is built, AUTO_CLOSE_CYCLES is unused, and activate occurs only for user requests.

Test Plan:
- Bench params: NUM_REQ=4, DEB_CYCLES=4, MOVE_TIMEOUT_CYCLES=50, AUTO_CLOSE_CYCLES=20.
- Reset, dn_max=1, req[2] held high 10 cycles -> activate pulse 7 cycles after rise with grant=4'b0100, busy=1; model up_m high 1 cycle later, drop after 10 -> busy=0.
- req[0] and req[3] debounced in same cycle, rr pointer=1 -> grant=4'b1000 first; next request pair req[0],req[3] -> grant=4'b0001.
- req pulse of 2 cycles (glitch) -> no pending, no activate.
- After activate, hold up_m=dn_m=0 for 3 cycles -> fault=1 on the 4th; fault_clr pulse -> IDLE, fault=0.
- Motor status held up_m=1 for 60 cycles -> fault=1 at move cycle 49; up_max=dn_max=1 in IDLE -> fault next cycle.
- AUTO_CLOSE_EN, up_max=1, no requests -> activate with grant=0 at idle cycle 19; same test without macro -> no activate for 100 cycles.

Source files
------------

// File: rtl/garage_door_activation_scheduler.sv
// Garage door request scheduler: sync/debounce, round-robin arbitration, motion supervision.
// Optional auto-close of an idle open door is built only when AUTO_CLOSE_EN is defined.
//
// state        | meaning
// S_IDLE       | accepting debounced request edges, waiting for a valid door position
// S_ISSUE      | activate pulse with grant to the winning source (or none for auto-close)
// S_WAIT_START | motor must report motion within 3 cycles
// S_MOVING     | motor running, timeout and limit combination supervised
// S_FAULT      | latched fault until fault_clr
module garage_door_activation_scheduler #(
  parameter int NUM_REQ             = 4,
  parameter int DEB_CYCLES          = 16,
  parameter int MOVE_TIMEOUT_CYCLES = 5000,
  parameter int AUTO_CLOSE_CYCLES   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               up_max,
  input  logic               dn_max,
  input  logic               up_m,
  input  logic               dn_m,
  input  logic               fault_clr,
  output logic               activate,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               fault
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int MW = $clog2(MOVE_TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(NUM_REQ);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [MW-1:0] MV_LAST  = MW'(MOVE_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_MOVING, S_FAULT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   sync1_q, sync2_q;
  logic [NUM_REQ-1:0]   deb_q, deb_d, deb_rise;
  logic [DW-1:0]        deb_cnt_q [NUM_REQ];
  logic [DW-1:0]        deb_cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [RW-1:0]        rr_q, rr_d;
  logic [1:0]           ws_cnt_q, ws_cnt_d;
  logic [MW-1:0]        mv_cnt_q, mv_cnt_d;
  logic                 activate_q, activate_d, busy_q, busy_d, fault_q, fault_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [RW-1:0]        win_idx, win_next;
  logic [NUM_REQ-1:0]   win_onehot;
  logic                 found;
  int                   idx;
  logic                 auto_fire;

  // A level changes only after DEB_CYCLES consecutive disagreeing samples
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
    deb_rise = deb_d & ~deb_q;
  end

  always_comb begin
    found      = 1'b0;
    win_idx    = '0;
    idx        = 0;
    win_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && pending_q[idx]) begin
        found   = 1'b1;
        win_idx = RW'(idx);
      end
    end
    win_onehot[win_idx] = 1'b1;
    win_next = (win_idx == RW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

`ifdef AUTO_CLOSE_EN
  localparam int IW = $clog2(AUTO_CLOSE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(AUTO_CLOSE_CYCLES - 1);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = '0;
    auto_fire  = 1'b0;
    if (state_q == S_IDLE && up_max && !dn_max && pending_q == '0) begin
      if (idle_cnt_q == IDLE_LAST) auto_fire = 1'b1;
      else                         idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`else
  // Feature not built: never fires for any legal cycle count.
  assign auto_fire = (AUTO_CLOSE_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    rr_d       = rr_q;
    ws_cnt_d   = ws_cnt_q;
    mv_cnt_d   = mv_cnt_q;
    activate_d = 1'b0;
    grant_d    = '0;
    case (state_q)
      S_IDLE: begin
        pending_d = pending_q | deb_rise;
        if (up_max && dn_max) begin
          state_d   = S_FAULT;
          pending_d = '0;
        end else if (pending_q != '0) begin
          if (up_max ^ dn_max) begin
            state_d    = S_ISSUE;
            activate_d = 1'b1;
            grant_d    = win_onehot;
            rr_d       = win_next;
            pending_d  = '0;
          end else begin
            pending_d = deb_rise;
          end
        end else if (auto_fire) begin
          state_d    = S_ISSUE;
          activate_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d   = S_WAIT_START;
        ws_cnt_d  = '0;
        pending_d = '0;
      end
      S_WAIT_START: begin
        if (up_m || dn_m) begin
          state_d  = S_MOVING;
          mv_cnt_d = '0;
        end else if (ws_cnt_q == 2'd2) begin
          state_d = S_FAULT;
        end else begin
          ws_cnt_d = ws_cnt_q + 1'b1;
        end
      end
      S_MOVING: begin
        if (up_m && dn_m)             state_d = S_FAULT;
        else if (!up_m && !dn_m)      state_d = S_IDLE;
        else if (mv_cnt_q == MV_LAST) state_d = S_FAULT;
        else                          mv_cnt_d = mv_cnt_q + 1'b1;
      end
      S_FAULT: begin
        pending_d = '0;
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      for (int i = 0; i < NUM_REQ; i++) deb_cnt_q[i] <= '0;
      pending_q  <= '0;
      rr_q       <= '0;
      ws_cnt_q   <= '0;
      mv_cnt_q   <= '0;
      activate_q <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= req;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      for (int i = 0; i < NUM_REQ; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      ws_cnt_q   <= ws_cnt_d;
      mv_cnt_q   <= mv_cnt_d;
      activate_q <= activate_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign activate = activate_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_garage_door_activation_scheduler.sv
// Directed bench for garage_door_activation_scheduler (small timing parameters).
// Define AUTO_CLOSE_EN for both bench and RTL to exercise auto-close.
module tb_garage_door_activation_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       up_max, dn_max, up_m, dn_m, fault_clr;
  logic       activate, busy, fault;
  logic [3:0] grant;
  int         checks = 0;
  int         errors = 0;
  int         n;
  logic       seen;

  garage_door_activation_scheduler #(
    .NUM_REQ(4), .DEB_CYCLES(4), .MOVE_TIMEOUT_CYCLES(50), .AUTO_CLOSE_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .up_max(up_max), .dn_max(dn_max),
    .up_m(up_m), .dn_m(dn_m), .fault_clr(fault_clr),
    .activate(activate), .grant(grant), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_act(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (activate !== 1'b1 && cnt < max);
  endtask

  task automatic settle();
    req = '0;
    repeat (12) tick();
  endtask

  // Motor reports up one cycle after activate, runs 10 cycles, then stops
  task automatic motion(input string tag);
    up_m = 1'b1;
    tick();
    check({tag, "_pulse"}, 32'(activate), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (9) tick();
    up_m = 1'b0;
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic serve(input string tag, input logic [3:0] pattern, input logic [3:0] exp_grant);
    req = pattern;
    wait_act(20, n);
    check({tag, "_lat"}, n, 32'd7);
    check({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    req = '0;
  endtask

  initial begin
    rst = 1'b0; req = '0; up_max = 1'b0; dn_max = 1'b1;
    up_m = 1'b0; dn_m = 1'b0; fault_clr = 1'b0;
    repeat (3) tick();
    check("rst_act", 32'(activate), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst = 1'b1;
    tick();

    serve("t1", 4'b0100, 4'b0100);
    check("t1_busy", 32'(busy), 32'd1);
    motion("t1");
    settle();

    serve("t2", 4'b0001, 4'b0001);
    motion("t2");
    settle();

    serve("t3", 4'b1001, 4'b1000);
    motion("t3");
    settle();

    serve("t4", 4'b1001, 4'b0001);
    motion("t4");
    settle();

    req = 4'b0010;
    tick();
    tick();
    req = '0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= activate;
    end
    check("glitch_act", 32'(seen), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);

    serve("start", 4'b0010, 4'b0010);
    repeat (3) tick();
    check("start_nofault", 32'(fault), 32'd0);
    tick();
    check("start_fault", 32'(fault), 32'd1);
    check("start_fault_act", 32'(activate), 32'd0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("start_clr_fault", 32'(fault), 32'd0);
    check("start_clr_busy", 32'(busy), 32'd0);
    settle();

    serve("tmo", 4'b1000, 4'b1000);
    up_m = 1'b1;
    repeat (51) tick();
    check("tmo_early", 32'(fault), 32'd0);
    tick();
    check("tmo_fault", 32'(fault), 32'd1);
    repeat (7) tick();
    up_m = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("tmo_clr", 32'(fault), 32'd0);
    settle();

    up_max = 1'b1;
    tick();
    check("limits_fault", 32'(fault), 32'd1);
    up_max = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("limits_clr", 32'(fault), 32'd0);

    up_max = 1'b1;
    dn_max = 1'b0;
`ifdef AUTO_CLOSE_EN
    wait_act(40, n);
    check("auto_lat", n, 32'd20);
    check("auto_grant", 32'(grant), 32'd0);
    dn_m = 1'b1;
    tick();
    tick();
    up_max = 1'b0;
    dn_max = 1'b1;
    dn_m = 1'b0;
    tick();
    check("auto_idle", 32'(busy), 32'd0);
`else
    seen = 1'b0;
    repeat (100) begin
      tick();
      seen |= activate;
    end
    check("noauto_act", 32'(seen), 32'd0);
    up_max = 1'b0;
    dn_max = 1'b1;
`endif
    settle();

    // rr pointer is 0 after serving source 3
    serve("rr_keep", 4'b0110, 4'b0010);
    up_m = 1'b1;
    repeat (4) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fault", 32'(fault), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_act", 32'(activate), 32'd0);
    up_m = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
